// File: rtl/step_judge_if.sv
// Bus between the level sequencer / pad logic (master) and the step judge (slave).
// Carries target pulses, pad levels, the done pulse and the grading/score outputs.
interface step_judge_if #(
    parameter int SCORE_W = 16,
    parameter int COMBO_W = 8
);
    logic               start;
    logic               tgt_left;
    logic               tgt_right;
    logic               tgt_up;
    logic               tgt_down;
    logic               done;
    logic               btn_left;
    logic               btn_right;
    logic               btn_up;
    logic               btn_down;
    logic               hit_perfect;
    logic               hit_good;
    logic               miss;
    logic [SCORE_W-1:0] score;
    logic [COMBO_W-1:0] combo;
    logic [COMBO_W-1:0] max_combo;
    logic               result_valid;

    modport master (
        output start, tgt_left, tgt_right, tgt_up, tgt_down, done,
               btn_left, btn_right, btn_up, btn_down,
        input  hit_perfect, hit_good, miss, score, combo, max_combo, result_valid
    );

    modport slave (
        input  start, tgt_left, tgt_right, tgt_up, tgt_down, done,
               btn_left, btn_right, btn_up, btn_down,
        output hit_perfect, hit_good, miss, score, combo, max_combo, result_valid
    );
endinterface

// File: rtl/step_judge.sv
// Grades pad presses against target pulses; keeps score, combo and max combo.
// Optional macro STEP_JUDGE_STRAY_PENALTY_EN: a stray press with no target clears combo.
module step_judge #(
    parameter int WINDOW      = 500,
    parameter int PERFECT_WIN = 100,
    parameter int SCORE_W     = 16,
    parameter int COMBO_W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    step_judge_if.slave  bus
);

    localparam int EW = $clog2(WINDOW + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_OPEN, S_DONE} state_t;

    state_t             r_state, w_state_nx;
    logic [3:0]         r_pat, w_pat_nx;
    logic [3:0]         r_got, w_got_nx;
    logic [EW-1:0]      r_elapsed, w_elapsed_nx;
    logic [3:0]         r_btn_q;
    logic               r_hit_perfect, r_hit_good, r_miss, r_result_valid;
    logic [SCORE_W-1:0] r_score;
    logic [COMBO_W-1:0] r_combo, r_max_combo;

    logic [3:0]         w_tgt, w_btn, w_press;
    logic               w_perfect, w_good, w_miss, w_clear, w_resolved;
    logic [COMBO_W-1:0] w_combo_inc;
`ifdef STEP_JUDGE_STRAY_PENALTY_EN
    logic               w_stray;
`endif

    function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] s,
                                                     input logic [1:0] inc);
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + (SCORE_W + 1)'(inc);
        return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    endfunction

    function automatic logic [COMBO_W-1:0] sat_combo(input logic [COMBO_W-1:0] c);
        return (&c) ? c : c + COMBO_W'(1);
    endfunction

    assign w_tgt       = {bus.tgt_left, bus.tgt_right, bus.tgt_up, bus.tgt_down};
    assign w_btn       = {bus.btn_left, bus.btn_right, bus.btn_up, bus.btn_down};
    assign w_press     = w_btn & ~r_btn_q;
    assign w_combo_inc = sat_combo(r_combo);

    always_comb begin
        w_state_nx   = r_state;
        w_pat_nx     = r_pat;
        w_got_nx     = r_got;
        w_elapsed_nx = r_elapsed;
        w_perfect    = 1'b0;
        w_good       = 1'b0;
        w_miss       = 1'b0;
        w_clear      = 1'b0;
        w_resolved   = 1'b0;
`ifdef STEP_JUDGE_STRAY_PENALTY_EN
        w_stray      = 1'b0;
`endif
        if (bus.start) begin
            w_clear      = 1'b1;
            w_state_nx   = S_ARMED;
            w_pat_nx     = '0;
            w_got_nx     = '0;
            w_elapsed_nx = '0;
        end else begin
            unique case (r_state)
                S_ARMED: begin
                    if (bus.done) begin
                        w_state_nx = S_DONE;
                    end else if (w_tgt != 4'd0) begin
                        // A press outside the arriving pattern spoils it immediately.
                        if ((w_press & ~w_tgt) != 4'd0) begin
                            w_miss = 1'b1;
                        end else begin
                            w_state_nx   = S_OPEN;
                            w_pat_nx     = w_tgt;
                            w_got_nx     = w_press & w_tgt;
                            w_elapsed_nx = '0;
                        end
`ifdef STEP_JUDGE_STRAY_PENALTY_EN
                    end else if (w_press != 4'd0) begin
                        w_stray = 1'b1;
`endif
                    end
                end
                S_OPEN: begin
                    if (bus.done) begin
                        w_miss     = 1'b1;
                        w_state_nx = S_DONE;
                        w_pat_nx   = '0;
                        w_got_nx   = '0;
                    end else begin
                        if ((w_press & ~r_pat) != 4'd0) begin
                            w_miss     = 1'b1;
                            w_resolved = 1'b1;
                        end else if ((r_got | w_press) == r_pat) begin
                            w_perfect  = (r_elapsed <= EW'(PERFECT_WIN));
                            w_good     = (r_elapsed >  EW'(PERFECT_WIN));
                            w_resolved = 1'b1;
                        end else if (r_elapsed == EW'(WINDOW)) begin
                            w_miss     = 1'b1;
                            w_resolved = 1'b1;
                        end
                        // Presses that resolved the old target are not credited to a new one.
                        if (w_resolved) begin
                            if (w_tgt != 4'd0) begin
                                w_pat_nx     = w_tgt;
                                w_got_nx     = '0;
                                w_elapsed_nx = '0;
                            end else begin
                                w_state_nx = S_ARMED;
                                w_pat_nx   = '0;
                                w_got_nx   = '0;
                            end
                        end else if (w_tgt != 4'd0) begin
                            w_miss       = 1'b1;
                            w_pat_nx     = w_tgt;
                            w_got_nx     = w_press & w_tgt;
                            w_elapsed_nx = '0;
                        end else begin
                            w_got_nx     = r_got | w_press;
                            w_elapsed_nx = r_elapsed + EW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_pat          <= '0;
            r_got          <= '0;
            r_elapsed      <= '0;
            r_btn_q        <= '0;
            r_hit_perfect  <= 1'b0;
            r_hit_good     <= 1'b0;
            r_miss         <= 1'b0;
            r_result_valid <= 1'b0;
            r_score        <= '0;
            r_combo        <= '0;
            r_max_combo    <= '0;
        end else begin
            r_state        <= w_state_nx;
            r_pat          <= w_pat_nx;
            r_got          <= w_got_nx;
            r_elapsed      <= w_elapsed_nx;
            r_btn_q        <= w_btn;
            r_hit_perfect  <= w_perfect;
            r_hit_good     <= w_good;
            r_miss         <= w_miss;
            r_result_valid <= !w_clear && (w_state_nx == S_DONE);
            if (w_clear) begin
                r_score     <= '0;
                r_combo     <= '0;
                r_max_combo <= '0;
            end else if (w_perfect || w_good) begin
                r_score     <= sat_score(r_score, w_perfect ? 2'd2 : 2'd1);
                r_combo     <= w_combo_inc;
                r_max_combo <= (w_combo_inc > r_max_combo) ? w_combo_inc : r_max_combo;
            end else if (w_miss) begin
                r_combo <= '0;
`ifdef STEP_JUDGE_STRAY_PENALTY_EN
            end else if (w_stray) begin
                r_combo <= '0;
`endif
            end
        end
    end

    assign bus.hit_perfect  = r_hit_perfect;
    assign bus.hit_good     = r_hit_good;
    assign bus.miss         = r_miss;
    assign bus.score        = r_score;
    assign bus.combo        = r_combo;
    assign bus.max_combo    = r_max_combo;
    assign bus.result_valid = r_result_valid;

endmodule

// File: tb/tb_step_judge.sv
// Bench for step_judge: vector table, directed multi-cycle sequences and a
// randomized run checked against a behavioural scoring model.
module tb_step_judge;

    localparam int WINDOW = 20;
    localparam int PW     = 5;
    localparam int SW     = 16;
    localparam int CW     = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    step_judge_if #(.SCORE_W(SW), .COMBO_W(CW)) bus ();

    step_judge #(.WINDOW(WINDOW), .PERFECT_WIN(PW), .SCORE_W(SW), .COMBO_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: phase 0 idle, 1 playing, 2 finished; m_age < 0 means no target.
    int       m_phase, m_age, m_score, m_combo, m_max;
    bit [3:0] m_need, m_have, m_bq;
    bit       m_p, m_g, m_m, m_rv;

    function automatic void model_reset();
        m_phase = 0; m_age = -1; m_score = 0; m_combo = 0; m_max = 0;
        m_need = 0; m_have = 0; m_bq = 0;
        m_p = 0; m_g = 0; m_m = 0; m_rv = 0;
    endfunction

    function automatic void model_step(bit s, bit [3:0] t, bit [3:0] b, bit d);
        bit [3:0] press;
        bit       res;
        press = b & ~m_bq;
        m_bq  = b;
        m_p = 0; m_g = 0; m_m = 0; res = 0;
        if (s) begin
            m_phase = 1; m_age = -1; m_score = 0; m_combo = 0; m_max = 0; m_rv = 0;
        end else if (m_phase == 1) begin
            if (d) begin
                if (m_age >= 0) m_m = 1;
                m_age = -1; m_phase = 2; m_rv = 1;
            end else if (m_age < 0) begin
                if (t != 0) begin
                    if ((press & ~t) != 0) m_m = 1;
                    else begin m_need = t; m_have = press & t; m_age = 0; end
                end else if (press != 0) begin
`ifdef STEP_JUDGE_STRAY_PENALTY_EN
                    m_combo = 0;
`endif
                end
            end else begin
                if ((press & ~m_need) != 0) begin m_m = 1; res = 1; end
                else if ((m_have | press) == m_need) begin
                    if (m_age <= PW) m_p = 1; else m_g = 1;
                    res = 1;
                end else if (m_age == WINDOW) begin m_m = 1; res = 1; end
                if (res) begin
                    if (t != 0) begin m_need = t; m_have = 0; m_age = 0; end
                    else m_age = -1;
                end else if (t != 0) begin
                    m_m = 1; m_need = t; m_have = press & t; m_age = 0;
                end else begin
                    m_have = m_have | press; m_age++;
                end
            end
        end
        if (m_p) m_score = (m_score + 2 > 65535) ? 65535 : m_score + 2;
        if (m_g) m_score = (m_score + 1 > 65535) ? 65535 : m_score + 1;
        if (m_p || m_g) begin
            m_combo = (m_combo == 255) ? 255 : m_combo + 1;
            if (m_combo > m_max) m_max = m_combo;
        end
        if (m_m) m_combo = 0;
    endfunction

    function automatic logic [35:0] dut_vec();
        return {bus.hit_perfect, bus.hit_good, bus.miss, bus.result_valid,
                bus.score, bus.combo, bus.max_combo};
    endfunction

    function automatic logic [35:0] mk_vec(bit p, bit g, bit m, bit rv, int sc, int co, int mx);
        return {p, g, m, rv, 16'(sc), 8'(co), 8'(mx)};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input bit s, input bit [3:0] t, input bit [3:0] b, input bit d);
        bus.start = s;
        {bus.tgt_left, bus.tgt_right, bus.tgt_up, bus.tgt_down} = t;
        {bus.btn_left, bus.btn_right, bus.btn_up, bus.btn_down} = b;
        bus.done  = d;
        @(posedge clk);
        model_step(s, t, b, d);
        #1;
    endtask

    typedef struct {
        bit       s;
        bit [3:0] t;
        bit [3:0] b;
        bit       d;
        bit       ep, eg, em;
        int       esc, eco, emx;
    } vec_t;

    vec_t tbl [17];

    initial begin
        bit [3:0] rb;
        int       early;

        // Bit order {left,right,up,down}: up=2, right=4, left=8, down=1.
        tbl[0]  = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
        tbl[1]  = '{1'b0, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
        tbl[2]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
        tbl[3]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
        tbl[4]  = '{1'b0, 4'h0, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1, 1};
        tbl[5]  = '{1'b0, 4'h0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1, 1};
        tbl[6]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1, 1};
        tbl[7]  = '{1'b0, 4'h4, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1, 1};
        tbl[8]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1, 1};
        tbl[9]  = '{1'b0, 4'h0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0, 1};
        tbl[10] = '{1'b0, 4'h0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 1};
        tbl[11] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 1};
        tbl[12] = '{1'b0, 4'h8, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0, 1};
        tbl[13] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 1};
        tbl[14] = '{1'b0, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 1};
        tbl[15] = '{1'b0, 4'h0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 4, 1, 1};
        tbl[16] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1, 1};

        model_reset();
        bus.start = 0; bus.done = 0;
        {bus.tgt_left, bus.tgt_right, bus.tgt_up, bus.tgt_down} = 4'h0;
        {bus.btn_left, bus.btn_right, bus.btn_up, bus.btn_down} = 4'h0;
        #22;
        check("reset_state", dut_vec(), mk_vec(0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;

        // IDLE ignores targets, presses and done.
        cyc(0, 4'h2, 4'h2, 0);
        cyc(0, 4'h0, 4'h0, 1);
        check("idle_ignore", dut_vec(), mk_vec(0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].s, tbl[i].t, tbl[i].b, tbl[i].d);
            check($sformatf("vec[%0d]", i), dut_vec(),
                  mk_vec(tbl[i].ep, tbl[i].eg, tbl[i].em, 1'b0, tbl[i].esc, tbl[i].eco, tbl[i].emx));
        end

        // Late press: GOOD.
        cyc(0, 4'h8, 4'h0, 0);
        for (int k = 1; k <= 11; k++) cyc(0, 4'h0, 4'h0, 0);
        cyc(0, 4'h0, 4'h8, 0);
        check("good_hit", dut_vec(), mk_vec(0, 1, 0, 0, 5, 2, 2));
        cyc(0, 4'h0, 4'h0, 0);
        check("good_pulse_width", dut_vec(), mk_vec(0, 0, 0, 0, 5, 2, 2));

        // No press: miss exactly when elapsed reaches WINDOW.
        cyc(0, 4'h1, 4'h0, 0);
        early = 0;
        for (int k = 1; k <= WINDOW; k++) begin
            cyc(0, 4'h0, 4'h0, 0);
            if (bus.miss || bus.hit_perfect || bus.hit_good) early++;
        end
        check("timeout_early_pulses", 64'(early), 64'd0);
        cyc(0, 4'h0, 4'h0, 0);
        check("timeout_miss", dut_vec(), mk_vec(0, 0, 1, 0, 5, 0, 2));
        cyc(0, 4'h0, 4'h0, 0);
        check("timeout_pulse_width", dut_vec(), mk_vec(0, 0, 0, 0, 5, 0, 2));

        // Overlapping target: old one missed, new one still gradable.
        cyc(0, 4'h2, 4'h0, 0);
        for (int k = 1; k <= 7; k++) cyc(0, 4'h0, 4'h0, 0);
        cyc(0, 4'h8, 4'h0, 0);
        check("overlap_miss", dut_vec(), mk_vec(0, 0, 1, 0, 5, 0, 2));
        cyc(0, 4'h0, 4'h0, 0);
        cyc(0, 4'h0, 4'h8, 0);
        check("overlap_new_perfect", dut_vec(), mk_vec(1, 0, 0, 0, 7, 1, 2));
        cyc(0, 4'h0, 4'h0, 0);

        // Three perfects then done with a target pending.
        cyc(1, 4'h0, 4'h0, 0);
        check("start_clears", dut_vec(), mk_vec(0, 0, 0, 0, 0, 0, 0));
        for (int h = 0; h < 3; h++) begin
            cyc(0, 4'h1, 4'h0, 0);
            cyc(0, 4'h0, 4'h1, 0);
            cyc(0, 4'h0, 4'h0, 0);
        end
        check("three_perfect", dut_vec(), mk_vec(0, 0, 0, 0, 6, 3, 3));
        cyc(0, 4'h1, 4'h0, 0);
        cyc(0, 4'h0, 4'h0, 0);
        cyc(0, 4'h0, 4'h0, 1);
        check("done_pending_miss", dut_vec(), mk_vec(0, 0, 1, 1, 6, 0, 3));
        cyc(0, 4'h1, 4'h1, 0);
        check("done_ignores_input", dut_vec(), mk_vec(0, 0, 0, 1, 6, 0, 3));
        cyc(0, 4'h0, 4'h0, 1);
        check("done_holds", dut_vec(), mk_vec(0, 0, 0, 1, 6, 0, 3));

        // Randomized run against the model.
        cyc(1, 4'h0, 4'h0, 0);
        rb = 4'h0;
        for (int i = 0; i < 4000; i++) begin
            bit       s, d;
            bit [3:0] t, flip;
            int       trate;
            trate = ((i / 500) % 2 == 0) ? 5 : 40;
            s = ($urandom_range(0, 299) == 0);
            d = ($urandom_range(0, 399) == 0);
            t = ($urandom_range(0, trate) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            flip = 4'h0;
            for (int j = 0; j < 4; j++) flip[j] = ($urandom_range(0, 5) == 0);
            rb = rb ^ flip;
            cyc(s, t, rb, d);
            check($sformatf("rand[%0d]", i), dut_vec(),
                  mk_vec(m_p, m_g, m_m, m_rv, m_score, m_combo, m_max));
        end

        // Asynchronous reset mid-window while a pulse is high.
        cyc(1, 4'h0, 4'h0, 0);
        cyc(0, 4'h2, 4'h0, 0);
        cyc(0, 4'h0, 4'h2, 0);
        check("pre_reset_hit", dut_vec(), mk_vec(1, 0, 0, 0, 2, 1, 1));
        #3 rst = 1'b0;
        #1;
        check("async_reset", dut_vec(), mk_vec(0, 0, 0, 0, 0, 0, 0));
        model_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
